c1_port_rx: RTL and testbench



---
 rtl/c1_pkg.sv | 16 +
 rtl/c1_fifo.sv | 58 +++++
 rtl/c1_port_rx.sv | 57 +++++
 tb/tb_c1_port_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/c1_pkg.sv
// Shared types and defaults for the c1 inter-core link blocks.
package c1_pkg;

    typedef bit [63:0] word_t;

    localparam int C1_PORT_DEPTH = 4;

    // Used to tag each link instance with the side of the core it serves.
    typedef enum logic [1:0] {
        NORTH = 2'd0,
        SOUTH = 2'd1,
        WEST  = 2'd2,
        EAST  = 2'd3
    } port_dir_e;

endpackage

// File: rtl/c1_fifo.sv
// Register-based FIFO with separate occupancy count and a combinational head word.
module c1_fifo
    import c1_pkg::*;
#(
    parameter int DEPTH = C1_PORT_DEPTH,
    parameter int WIDTH = $bits(word_t),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/c1_port_rx.sv
// Receive end of a c1 neighbour link: buffers pushed words for the local core,
// flags reads from an empty port and latches a sticky overflow on dropped writes.
module c1_port_rx
    import c1_pkg::*;
#(
    parameter int DEPTH = C1_PORT_DEPTH,
    parameter int WIDTH = $bits(word_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         link_dat,
    input  logic                     link_we,
    output logic                     link_rdy,
    input  logic                     core_re,
    output logic [WIDTH-1:0]         core_dat,
    output logic                     core_valid,
    output logic                     core_stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Ready and valid come only from registered occupancy: no same-cycle bypass.
    assign link_rdy   = !full;
    assign core_valid = !empty;
    assign core_stall = core_re && empty;
    assign push       = link_we && link_rdy;
    assign pop        = core_re && core_valid;

    c1_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (link_dat),
        .pop      (pop),
        .head     (core_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (link_we && !link_rdy) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_c1_port_rx.sv
// Bench for c1_port_rx: per-cycle vector table, stream and random phases, async reset check.
module tb_c1_port_rx;

    localparam int DEPTH = 4;
    localparam int WIDTH = 64;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] link_dat;
    logic             link_we;
    logic             link_rdy;
    logic             core_re;
    logic [WIDTH-1:0] core_dat;
    logic             core_valid;
    logic             core_stall;
    logic [2:0]       count;
    logic             ovf;

    c1_port_rx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .link_dat   (link_dat),
        .link_we    (link_we),
        .link_rdy   (link_rdy),
        .core_re    (core_re),
        .core_dat   (core_dat),
        .core_valid (core_valid),
        .core_stall (core_stall),
        .count      (count),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference occupancy model.
    logic [WIDTH-1:0] exp_q[$];
    int               m_count = 0;
    logic             m_ovf   = 1'b0;

    typedef struct {
        logic             we;
        logic [WIDTH-1:0] dat;
        logic             re;
        logic             e_rdy;
        logic             e_valid;
        logic             e_stall;
        logic [2:0]       e_count;
        logic             e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic add(input logic we, input logic [WIDTH-1:0] dat, input logic re,
                       input logic rdy, input logic valid, input logic stall,
                       input logic [2:0] cnt, input logic ov);
        vec_t v;
        v.we = we; v.dat = dat; v.re = re;
        v.e_rdy = rdy; v.e_valid = valid; v.e_stall = stall;
        v.e_count = cnt; v.e_ovf = ov;
        vecs.push_back(v);
    endtask

    // Apply inputs on the falling edge and let combinational outputs settle.
    task automatic drive(input logic we, input logic [WIDTH-1:0] dat, input logic re);
        @(negedge clk);
        link_we  = we;
        link_dat = dat;
        core_re  = re;
        #1;
    endtask

    // Score the cycle against the model, then advance the model past the next rising edge.
    task automatic sb_update();
        logic m_rdy;
        logic m_valid;
        logic do_push;
        logic do_pop;
        m_rdy   = (m_count != DEPTH);
        m_valid = (m_count != 0);
        do_push = link_we && m_rdy;
        do_pop  = core_re && m_valid;
        if (do_pop) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk("pop_data", core_dat, exp_q.pop_front());
            end
        end
        if (do_push) exp_q.push_back(link_dat);
        if (link_we && !m_rdy) m_ovf = 1'b1;
        m_count = m_count + int'(do_push) - int'(do_pop);
    endtask

    task automatic chk_model();
        chk("link_rdy", link_rdy, m_count != DEPTH);
        chk("core_valid", core_valid, m_count != 0);
        chk("core_stall", core_stall, core_re && (m_count == 0));
        chk("count", count, m_count);
        chk("ovf", ovf, m_ovf);
    endtask

    initial begin
        rst = 1'b1; link_we = 1'b0; link_dat = '0; core_re = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy", link_rdy, 1);
        chk("rst_valid", core_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dat", core_dat, 0);

        // we, dat, re | rdy valid stall count ovf (values seen before the edge)
        add(1, 64'hA, 0,  1, 0, 0, 0, 0);
        add(1, 64'hB, 0,  1, 1, 0, 1, 0);
        add(1, 64'hC, 0,  1, 1, 0, 2, 0);
        add(0, 64'h0, 0,  1, 1, 0, 3, 0);
        add(0, 64'h0, 1,  1, 1, 0, 3, 0);
        add(0, 64'h0, 1,  1, 1, 0, 2, 0);
        add(0, 64'h0, 1,  1, 1, 0, 1, 0);
        add(0, 64'h0, 0,  1, 0, 0, 0, 0);
        add(1, 64'h11, 0, 1, 0, 0, 0, 0);
        add(1, 64'h22, 0, 1, 1, 0, 1, 0);
        add(1, 64'h33, 0, 1, 1, 0, 2, 0);
        add(1, 64'h44, 0, 1, 1, 0, 3, 0);
        add(1, 64'hDEAD, 0, 0, 1, 0, 4, 0);
        add(0, 64'h0, 0,  0, 1, 0, 4, 1);
        add(1, 64'hBEEF, 1, 0, 1, 0, 4, 1);
        add(0, 64'h0, 0,  1, 1, 0, 3, 1);
        add(0, 64'h0, 1,  1, 1, 0, 3, 1);
        add(0, 64'h0, 1,  1, 1, 0, 2, 1);
        add(0, 64'h0, 1,  1, 1, 0, 1, 1);
        add(0, 64'h0, 0,  1, 0, 0, 0, 1);
        add(0, 64'h0, 1,  1, 0, 1, 0, 1);
        add(1, 64'h5, 1,  1, 0, 1, 0, 1);
        add(0, 64'h0, 1,  1, 1, 0, 1, 1);
        add(0, 64'h0, 0,  1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].dat, vecs[i].re);
            chk($sformatf("v%0d_rdy", i), link_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d_valid", i), core_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_stall", i), core_stall, vecs[i].e_stall);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].e_ovf);
            sb_update();
        end

        // Stream: push every cycle, pop every cycle after the first, across pointer wrap.
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, 64'h1000 + 64'(i), i > 0);
            chk_model();
            if (i >= 2) chk("stream_cnt_le1", count <= 3'd1, 1);
            sb_update();
        end

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
            chk_model();
            sb_update();
        end

        // Drain, then set up count=2 for the async reset check.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1);
            sb_update();
        end
        drive(1, 64'h71, 0); sb_update();
        drive(1, 64'h72, 0); sb_update();
        drive(0, 0, 0);
        chk("pre_rst_count", count, 2);
        sb_update();

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_rdy", link_rdy, 1);
        chk("arst_valid", core_valid, 0);
        chk("arst_dat", core_dat, 0);
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;

        // Release on a falling edge with a push already presented.
        @(negedge clk);
        rst      = 1'b0;
        link_we  = 1'b1;
        link_dat = 64'h77;
        core_re  = 1'b0;
        #1;
        sb_update();
        drive(0, 0, 1);
        chk("post_rst_count", count, 1);
        chk("post_rst_valid", core_valid, 1);
        sb_update();
        drive(0, 0, 0);
        chk_model();
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
